// File: rtl/axis_proc_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-Stream processor between NUM_SRC sources.
// Per-source mode/constant settings are snapshotted at grant and held for the whole packet.
module axis_proc_arbiter #(
  parameter int TDATA_WIDTH = 32,
  parameter int NUM_SRC     = 2,
  parameter int SRC_W       = 2
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic [NUM_SRC*TDATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [NUM_SRC*TDATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [NUM_SRC-1:0]                s_axis_tlast,
  input  logic [NUM_SRC-1:0]                s_axis_tvalid,
  output logic [NUM_SRC-1:0]                s_axis_tready,
  output logic [TDATA_WIDTH-1:0]            m_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0]          m_axis_tkeep,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [1:0]                        mode,
  output logic [TDATA_WIDTH-1:0]            constant_value,
  input  logic                              cfg_wr_en,
  input  logic [SRC_W-1:0]                  cfg_wr_src,
  input  logic [1:0]                        cfg_wr_mode,
  input  logic [TDATA_WIDTH-1:0]            cfg_wr_const,
  output logic                              grant_valid,
  output logic [SRC_W-1:0]                  grant_src,
  output logic [NUM_SRC*16-1:0]             pkt_count,
  output logic                              o_dbg_state,
  output logic [SRC_W-1:0]                  o_dbg_rr_ptr
);

  localparam int KW = TDATA_WIDTH / 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [SRC_W-1:0]        r_rr_ptr;
  logic [SRC_W-1:0]        r_grant_src;
  logic                    r_grant_valid;
  logic [1:0]              r_mode;
  logic [TDATA_WIDTH-1:0]  r_const;
  logic [1:0]              r_cfg_mode  [NUM_SRC];
  logic [TDATA_WIDTH-1:0]  r_cfg_const [NUM_SRC];
  logic [15:0]             r_pkt_cnt   [NUM_SRC];

  logic                    w_any_req;
  logic [SRC_W-1:0]        w_sel;
  logic [1:0]              w_sel_mode;
  logic [TDATA_WIDTH-1:0]  w_sel_const;
  logic                    w_xfer;
  logic                    w_last_xfer;
  int                      w_dist;
  int                      w_best;

  // Pick the requester closest to r_rr_ptr going upward with wrap-around.
  always_comb begin
    w_any_req   = 1'b0;
    w_sel       = '0;
    w_sel_mode  = '0;
    w_sel_const = '0;
    w_dist      = 0;
    w_best      = NUM_SRC;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_dist = (i + NUM_SRC - int'(r_rr_ptr)) % NUM_SRC;
      if (s_axis_tvalid[i] && (w_dist < w_best)) begin
        w_best      = w_dist;
        w_any_req   = 1'b1;
        w_sel       = SRC_W'(i);
        w_sel_mode  = r_cfg_mode[i];
        w_sel_const = r_cfg_const[i];
      end
    end
  end

  // Handshake: a beat moves when valid && ready on the same edge; the granted
  // source sees the processor's tready directly, every other source sees 0.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    if ((r_state == ST_GRANT) && !areset) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (r_grant_src == SRC_W'(i)) begin
          m_axis_tdata     = s_axis_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
          m_axis_tkeep     = s_axis_tkeep[i*KW +: KW];
          m_axis_tlast     = s_axis_tlast[i];
          m_axis_tvalid    = s_axis_tvalid[i];
          s_axis_tready[i] = m_axis_tready;
        end
      end
    end
  end

  assign w_xfer      = m_axis_tvalid && m_axis_tready;
  assign w_last_xfer = w_xfer && m_axis_tlast;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_any_req)   w_next_state = ST_GRANT;
      ST_GRANT: if (w_last_xfer) w_next_state = ST_IDLE;
      default:                   w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state       <= ST_IDLE;
      r_rr_ptr      <= '0;
      r_grant_src   <= '0;
      r_grant_valid <= 1'b0;
      r_mode        <= '0;
      r_const       <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        r_cfg_mode[i]  <= '0;
        r_cfg_const[i] <= '0;
        r_pkt_cnt[i]   <= '0;
      end
    end else begin
      r_state <= w_next_state;
      // Out-of-range indices match no slot and are dropped.
      for (int i = 0; i < NUM_SRC; i++) begin
        if (cfg_wr_en && (cfg_wr_src == SRC_W'(i))) begin
          r_cfg_mode[i]  <= cfg_wr_mode;
          r_cfg_const[i] <= cfg_wr_const;
        end
      end
      // Snapshot reads the pre-edge config, so a same-edge write lands next packet.
      if ((r_state == ST_IDLE) && w_any_req) begin
        r_grant_src   <= w_sel;
        r_grant_valid <= 1'b1;
        r_mode        <= w_sel_mode;
        r_const       <= w_sel_const;
      end
      if (w_last_xfer) begin
        r_grant_valid <= 1'b0;
        r_rr_ptr      <= (r_grant_src == SRC_W'(NUM_SRC - 1)) ? '0 : r_grant_src + 1'b1;
        for (int i = 0; i < NUM_SRC; i++) begin
          if (r_grant_src == SRC_W'(i)) r_pkt_cnt[i] <= r_pkt_cnt[i] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    pkt_count = '0;
    for (int i = 0; i < NUM_SRC; i++) pkt_count[i*16 +: 16] = r_pkt_cnt[i];
  end

  assign mode           = r_mode;
  assign constant_value = r_const;
  assign grant_valid    = r_grant_valid;
  assign grant_src      = r_grant_src;
  assign o_dbg_state    = r_state;
  assign o_dbg_rr_ptr   = r_rr_ptr;

endmodule

// File: tb/tb_axis_proc_arbiter.sv
// Bench for axis_proc_arbiter: config/grant vector table plus hand-written multi-cycle sequences,
// with a scoreboard of expected processor-side beats in arbitration order.
module tb_axis_proc_arbiter;

  localparam int DW    = 32;
  localparam int NS    = 2;
  localparam int SW    = 2;
  localparam int KW    = DW / 8;
  localparam int EXP_W = 2 + 2 + DW + 1 + DW;
  localparam logic [KW-1:0] KEEP0 = 4'hF;
  localparam logic [KW-1:0] KEEP1 = 4'h3;

  typedef struct packed {
    logic [1:0]    src;
    logic [1:0]    mode;
    logic [DW-1:0] cst;
    logic          last;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct packed {
    logic [1:0]    wr_src;
    logic [1:0]    wr_mode;
    logic [DW-1:0] wr_const;
    logic [1:0]    req_src;
    logic [1:0]    exp_mode;
    logic [DW-1:0] exp_const;
  } vec_t;

  logic                 aclk;
  logic                 areset;
  logic [NS*DW-1:0]     s_axis_tdata;
  logic [NS*KW-1:0]     s_axis_tkeep;
  logic [NS-1:0]        s_axis_tlast;
  logic [NS-1:0]        s_axis_tvalid;
  logic [NS-1:0]        s_axis_tready;
  logic [DW-1:0]        m_axis_tdata;
  logic [KW-1:0]        m_axis_tkeep;
  logic                 m_axis_tlast;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic [1:0]           mode;
  logic [DW-1:0]        constant_value;
  logic                 cfg_wr_en;
  logic [SW-1:0]        cfg_wr_src;
  logic [1:0]           cfg_wr_mode;
  logic [DW-1:0]        cfg_wr_const;
  logic                 grant_valid;
  logic [SW-1:0]        grant_src;
  logic [NS*16-1:0]     pkt_count;
  logic                 dbg_state;
  logic [SW-1:0]        dbg_rr_ptr;

  logic [EXP_W-1:0] exp_q[$];
  logic [DW:0]      q0[$];
  logic [DW:0]      q1[$];
  logic [NS-1:0]    en;
  logic [15:0]      exp_cnt0;
  logic [15:0]      exp_cnt1;
  logic             prev_last;
  int               n_checks;
  int               n_fail;
  vec_t             vecs[6];

  axis_proc_arbiter #(.TDATA_WIDTH(DW), .NUM_SRC(NS), .SRC_W(SW)) dut (
    .aclk           (aclk),
    .areset         (areset),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tkeep   (s_axis_tkeep),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .mode           (mode),
    .constant_value (constant_value),
    .cfg_wr_en      (cfg_wr_en),
    .cfg_wr_src     (cfg_wr_src),
    .cfg_wr_mode    (cfg_wr_mode),
    .cfg_wr_const   (cfg_wr_const),
    .grant_valid    (grant_valid),
    .grant_src      (grant_src),
    .pkt_count      (pkt_count),
    .o_dbg_state    (dbg_state),
    .o_dbg_rr_ptr   (dbg_rr_ptr)
  );

  // Clock and watchdog
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drivers
  task automatic drive_inputs();
    logic [DW:0] b;
    b = '0;
    if (q0.size() > 0) b = q0[0];
    s_axis_tvalid[0]       = en[0] && (q0.size() > 0);
    s_axis_tdata[0 +: DW]  = b[DW-1:0];
    s_axis_tlast[0]        = b[DW];
    b = '0;
    if (q1.size() > 0) b = q1[0];
    s_axis_tvalid[1]       = en[1] && (q1.size() > 0);
    s_axis_tdata[DW +: DW] = b[DW-1:0];
    s_axis_tlast[1]        = b[DW];
    s_axis_tkeep           = {KEEP1, KEEP0};
  endtask

  task automatic push_beat(input int src, input logic [DW-1:0] data, input logic last,
                           input logic [1:0] emode, input logic [DW-1:0] ecst);
    exp_t e;
    e.src  = 2'(src);
    e.mode = emode;
    e.cst  = ecst;
    e.last = last;
    e.data = data;
    exp_q.push_back(e);
    if (src == 0) q0.push_back({last, data});
    else          q1.push_back({last, data});
    drive_inputs();
  endtask

  task automatic push_pkt(input int src, input int nbeats, input logic [1:0] emode,
                          input logic [DW-1:0] ecst);
    for (int b = 0; b < nbeats; b++)
      push_beat(src, DW'($urandom()), (b == nbeats - 1), emode, ecst);
  endtask

  task automatic cfg_write(input logic [SW-1:0] src, input logic [1:0] m, input logic [DW-1:0] c);
    cfg_wr_en    = 1'b1;
    cfg_wr_src   = src;
    cfg_wr_mode  = m;
    cfg_wr_const = c;
    cycle();
    cfg_wr_en    = 1'b0;
  endtask

  // One clock: sample and score at the falling edge, then re-drive just after the rising edge.
  task automatic cycle();
    exp_t e;
    logic xfer;
    @(negedge aclk);
    xfer = m_axis_tvalid && m_axis_tready;
    if (prev_last) check("bubble_grant_valid", {63'd0, grant_valid}, 64'd0);
    if (grant_valid === 1'b0) begin
      check("idle_m_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
      check("idle_s_tready", {62'd0, s_axis_tready}, 64'd0);
    end
    if (xfer) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got data 0x%0h from src %0d, expected no beat",
                 m_axis_tdata, grant_src);
      end else begin
        e = exp_t'(exp_q.pop_front());
        check("beat_src",   {62'd0, grant_src},      {62'd0, e.src});
        check("beat_mode",  {62'd0, mode},           {62'd0, e.mode});
        check("beat_const", {32'd0, constant_value}, {32'd0, e.cst});
        check("beat_data",  {32'd0, m_axis_tdata},   {32'd0, e.data});
        check("beat_last",  {63'd0, m_axis_tlast},   {63'd0, e.last});
        check("beat_keep",  {60'd0, m_axis_tkeep},   {60'd0, (e.src == 2'd0) ? KEEP0 : KEEP1});
        if (e.last) begin
          if (e.src == 2'd0) exp_cnt0 = exp_cnt0 + 16'd1;
          else               exp_cnt1 = exp_cnt1 + 16'd1;
        end
      end
    end
    if (s_axis_tvalid[0] && s_axis_tready[0] && (q0.size() > 0)) void'(q0.pop_front());
    if (s_axis_tvalid[1] && s_axis_tready[1] && (q1.size() > 0)) void'(q1.pop_front());
    prev_last = xfer && m_axis_tlast;
    @(posedge aclk);
    #1;
    drive_inputs();
  endtask

  task automatic run_until_empty(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0) && (n < budget)) begin
      cycle();
      n++;
    end
    check("drain_exp_q", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_counts(input string name);
    check(name, {32'd0, pkt_count}, {32'd0, exp_cnt1, exp_cnt0});
  endtask

  // Scoreboard-driven test sequence and final report
  initial begin
    logic [DW-1:0] hold;
    logic [31:0]   snap;
    int            n;

    vecs[0] = '{2'd0, 2'd1, 32'hA5A5_0001, 2'd0, 2'd1, 32'hA5A5_0001};
    vecs[1] = '{2'd1, 2'd3, 32'h0000_00FF, 2'd1, 2'd3, 32'h0000_00FF};
    vecs[2] = '{2'd3, 2'd2, 32'hDEAD_BEEF, 2'd0, 2'd1, 32'hA5A5_0001};
    vecs[3] = '{2'd2, 2'd2, 32'h0000_1234, 2'd1, 2'd3, 32'h0000_00FF};
    vecs[4] = '{2'd1, 2'd0, 32'hFFFF_FFFF, 2'd1, 2'd0, 32'hFFFF_FFFF};
    vecs[5] = '{2'd0, 2'd2, 32'h0000_0000, 2'd0, 2'd2, 32'h0000_0000};

    n_checks = 0;
    n_fail = 0;
    prev_last = 1'b0;
    exp_cnt0 = '0;
    exp_cnt1 = '0;
    areset = 1'b1;
    m_axis_tready = 1'b1;
    en = '1;
    cfg_wr_en = 1'b0;
    cfg_wr_src = '0;
    cfg_wr_mode = '0;
    cfg_wr_const = '0;
    drive_inputs();
    repeat (3) cycle();
    areset = 1'b0;

    check("rst_grant_valid", {63'd0, grant_valid}, 64'd0);
    check("rst_grant_src", {62'd0, grant_src}, 64'd0);
    check("rst_mode", {62'd0, mode}, 64'd0);
    check("rst_const", {32'd0, constant_value}, 64'd0);
    check("rst_pkt_count", {32'd0, pkt_count}, 64'd0);
    check("rst_state", {63'd0, dbg_state}, 64'd0);
    check("rst_rr_ptr", {62'd0, dbg_rr_ptr}, 64'd0);

    // Config writes (including ignored out-of-range targets) observed through the next grant.
    foreach (vecs[i]) begin
      cfg_write(vecs[i].wr_src, vecs[i].wr_mode, vecs[i].wr_const);
      push_pkt(int'(vecs[i].req_src), 1, vecs[i].exp_mode, vecs[i].exp_const);
      run_until_empty(10);
      check("vec_mode_held", {62'd0, mode}, {62'd0, vecs[i].exp_mode});
      check("vec_const_held", {32'd0, constant_value}, {32'd0, vecs[i].exp_const});
    end
    check_counts("vec_pkt_count");
    check("vec_rr_ptr", {62'd0, dbg_rr_ptr}, 64'd1);

    // Round robin with both sources requesting; pointer currently favours src1.
    cfg_write(2'd0, 2'd0, 32'd0);
    cfg_write(2'd1, 2'd1, 32'd0);
    push_beat(1, 32'h1234_5678, 1'b1, 2'd1, 32'd0);
    push_beat(0, 32'h1234_5678, 1'b1, 2'd0, 32'd0);
    push_beat(1, 32'h1234_5678, 1'b1, 2'd1, 32'd0);
    push_beat(0, 32'h1234_5678, 1'b1, 2'd0, 32'd0);
    run_until_empty(30);
    check_counts("rr_pkt_count");

    // Multi-beat lock: src1 owns the stream for 3 beats while src0 waits.
    push_pkt(1, 3, 2'd1, 32'd0);
    push_beat(0, DW'($urandom()), 1'b1, 2'd0, 32'd0);
    n = 0;
    while ((q1.size() > 0) && (n < 20)) begin
      check("lock_tready0", {63'd0, s_axis_tready[0]}, 64'd0);
      cycle();
      n++;
    end
    check("lock_bubble", {63'd0, grant_valid}, 64'd0);
    cycle();
    check("lock_next_valid", {63'd0, grant_valid}, 64'd1);
    check("lock_next_src", {62'd0, grant_src}, 64'd0);
    run_until_empty(10);

    // Backpressure for 3 cycles mid-packet.
    push_pkt(1, 3, 2'd1, 32'd0);
    n = 0;
    while ((q1.size() > 2) && (n < 10)) begin
      cycle();
      n++;
    end
    m_axis_tready = 1'b0;
    hold = q1[0][DW-1:0];
    snap = {exp_cnt1, exp_cnt0};
    repeat (3) begin
      cycle();
      check("bp_tdata", {32'd0, m_axis_tdata}, {32'd0, hold});
      check("bp_grant_src", {62'd0, grant_src}, 64'd1);
      check("bp_grant_valid", {63'd0, grant_valid}, 64'd1);
      check("bp_s_tready", {62'd0, s_axis_tready}, 64'd0);
      check("bp_pkt_count", {32'd0, pkt_count}, {32'd0, snap});
    end
    m_axis_tready = 1'b1;
    run_until_empty(10);
    check_counts("bp_pkt_count_after");

    // Source drops tvalid mid-packet: grant is kept.
    push_pkt(0, 2, 2'd0, 32'd0);
    n = 0;
    while ((q0.size() > 1) && (n < 10)) begin
      cycle();
      n++;
    end
    en[0] = 1'b0;
    drive_inputs();
    repeat (2) begin
      cycle();
      check("drop_grant_valid", {63'd0, grant_valid}, 64'd1);
      check("drop_grant_src", {62'd0, grant_src}, 64'd0);
      check("drop_m_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    end
    en[0] = 1'b1;
    drive_inputs();
    run_until_empty(10);

    // Config shadowing: a mid-packet write to the granted source waits for its next grant.
    cfg_write(2'd0, 2'd2, 32'h0000_0005);
    push_pkt(0, 3, 2'd2, 32'h0000_0005);
    n = 0;
    while ((q0.size() > 2) && (n < 10)) begin
      cycle();
      n++;
    end
    cfg_write(2'd0, 2'd2, 32'hFFFF_FFFF);
    check("shadow_const_mid", {32'd0, constant_value}, 64'h5);
    run_until_empty(10);
    check("shadow_const_end", {32'd0, constant_value}, 64'h5);
    push_beat(0, 32'hFFFF_FFFF, 1'b1, 2'd2, 32'hFFFF_FFFF);
    run_until_empty(10);
    check("shadow_const_next", {32'd0, constant_value}, 64'hFFFF_FFFF);

    // Write to the selected source on the same edge as its grant: old value is snapshotted.
    cfg_wr_en    = 1'b1;
    cfg_wr_src   = 2'd1;
    cfg_wr_mode  = 2'd3;
    cfg_wr_const = 32'h0000_0077;
    push_beat(1, DW'($urandom()), 1'b1, 2'd1, 32'd0);
    cycle();
    cfg_wr_en = 1'b0;
    check("coll_mode_old", {62'd0, mode}, 64'd1);
    run_until_empty(10);
    push_beat(1, DW'($urandom()), 1'b1, 2'd3, 32'h0000_0077);
    run_until_empty(10);
    check("coll_mode_new", {62'd0, mode}, 64'd3);
    check_counts("coll_pkt_count");

    // Reset during beat 2 of 3 abandons the packet and clears all state.
    push_pkt(0, 3, 2'd2, 32'hFFFF_FFFF);
    n = 0;
    while ((q0.size() > 2) && (n < 10)) begin
      cycle();
      n++;
    end
    areset = 1'b1;
    cycle();
    check("mid_rst_m_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    check("mid_rst_s_tready", {62'd0, s_axis_tready}, 64'd0);
    cycle();
    areset = 1'b0;
    q0.delete();
    q1.delete();
    exp_q.delete();
    exp_cnt0 = '0;
    exp_cnt1 = '0;
    prev_last = 1'b0;
    drive_inputs();
    check("mid_rst_grant_valid", {63'd0, grant_valid}, 64'd0);
    check("mid_rst_s_tready_after", {62'd0, s_axis_tready}, 64'd0);
    check("mid_rst_mode", {62'd0, mode}, 64'd0);
    check("mid_rst_const", {32'd0, constant_value}, 64'd0);
    check("mid_rst_pkt_count", {32'd0, pkt_count}, 64'd0);
    check("mid_rst_rr_ptr", {62'd0, dbg_rr_ptr}, 64'd0);
    check("mid_rst_state", {63'd0, dbg_state}, 64'd0);
    push_beat(1, DW'($urandom()), 1'b1, 2'd0, 32'd0);
    run_until_empty(10);
    check_counts("post_rst_pkt_count");

    check("final_exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
